// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect-4 win checker.
//   - Board geometry constants (ROWS, COLS, WIN_LEN, CELLS).
//   - token_t: encoding of one board cell (2'b11 is an invalid cell value).
//   - chk_state_t: scan controller states.
//   - is_player(): true for a cell owned by player 1 or player 2.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int CELLS   = ROWS * COLS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } token_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } chk_state_t;

  function automatic logic is_player(input logic [1:0] v);
    return (v == P1) || (v == P2);
  endfunction

endpackage

// File: rtl/connect4_window_match.sv
// Combinational four-cell window comparator.
//   cell0..cell3 : the four cells of one candidate run, anchor first
//   match        : all four cells hold the same player token (01 or 10)
//   owner        : that player on a match, 2'b00 otherwise
module connect4_window_match
  import connect4_pkg::*;
(
  input  logic [1:0] cell0,
  input  logic [1:0] cell1,
  input  logic [1:0] cell2,
  input  logic [1:0] cell3,
  output logic       match,
  output logic [1:0] owner
);

  // Empty and invalid (11) cells can never form a run, even four in a row.
  assign match = is_player(cell0) && (cell0 == cell1) &&
                 (cell1 == cell2) && (cell2 == cell3);
  assign owner = match ? cell0 : EMPTY;

endmodule

// File: rtl/connect4_win_checker.sv
// Connect-4 game-end detector.
// On a start pulse the board is copied into a snapshot and scanned one anchor
// cell per cycle (row-major). Each anchor is tested for horizontal, vertical,
// down-right and down-left runs of four, in that priority order. The first hit
// ends the scan; otherwise the scan runs to the last cell and reports a draw if
// the board is full.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   tokens       : live board, tokens[r][c], row 0 = top, col 0 = left
//   start        : one-cycle request to check the board as presented this cycle
//   clear        : new game; aborts any scan and zeroes the results
//   busy         : a snapshot is being scanned
//   done         : one-cycle pulse when winner/draw/win_mask are fresh
//   winner       : 00 none, 01 player 1, 10 player 2
//   draw         : board full with no winner
//   win_mask     : bit r*COLS+c set for each cell of the winning run
module connect4_win_checker
  import connect4_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       tokens [ROWS][COLS],
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             draw,
  output logic [CELLS-1:0] win_mask
);

  localparam logic [2:0]       LAST_COL   = 3'(COLS - 1);
  localparam logic [2:0]       MAX_H_COL  = 3'(COLS - WIN_LEN);
  localparam logic [2:0]       MAX_V_ROW  = 3'(ROWS - WIN_LEN);
  localparam logic [2:0]       MIN_DL_COL = 3'(WIN_LEN - 1);
  localparam logic [5:0]       LAST_IDX   = 6'(CELLS - 1);
  localparam logic [CELLS-1:0] ONE        = CELLS'(1);

  chk_state_t state, state_next;

  logic [1:0] snap [ROWS][COLS];
  logic [5:0] idx;
  logic [2:0] row;
  logic [2:0] col;
  logic       empty_seen;

  logic [1:0] h_c  [WIN_LEN];
  logic [1:0] v_c  [WIN_LEN];
  logic [1:0] dr_c [WIN_LEN];
  logic [1:0] dl_c [WIN_LEN];

  logic       h_match, v_match, dr_match, dl_match;
  logic [1:0] h_owner, v_owner, dr_owner, dl_owner;
  logic       h_en, v_en, dr_en, dl_en;

  int               anchor_r, anchor_c, anchor_base;
  logic             anchor_empty;
  logic             hit;
  logic [1:0]       hit_owner;
  logic [CELLS-1:0] hit_mask;
  logic             scan_last;

  // Off-board coordinates read as empty, so windows that overhang the edge
  // never match even before the enable terms are applied.
  function automatic logic [1:0] cell_at(input logic [1:0] b [ROWS][COLS],
                                         input int r, input int c);
    logic [1:0] v;
    v = EMPTY;
    if (r >= 0 && r < ROWS && c >= 0 && c < COLS) v = b[r[2:0]][c[2:0]];
    return v;
  endfunction

  // Four-bit run mask starting at flat index base, stepping by stride.
  function automatic logic [CELLS-1:0] run_mask(input int base, input int stride);
    logic [CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < WIN_LEN; i++) m |= ONE << (base + i * stride);
    return m;
  endfunction

  // Gather the four candidate windows around the current anchor.
  always_comb begin
    anchor_r    = int'(row);
    anchor_c    = int'(col);
    anchor_base = int'(idx);
    for (int i = 0; i < WIN_LEN; i++) begin
      h_c[i]  = cell_at(snap, anchor_r,     anchor_c + i);
      v_c[i]  = cell_at(snap, anchor_r + i, anchor_c);
      dr_c[i] = cell_at(snap, anchor_r + i, anchor_c + i);
      dl_c[i] = cell_at(snap, anchor_r + i, anchor_c - i);
    end
    anchor_empty = ~is_player(cell_at(snap, anchor_r, anchor_c));
  end

  connect4_window_match u_match_h (
    .cell0(h_c[0]), .cell1(h_c[1]), .cell2(h_c[2]), .cell3(h_c[3]),
    .match(h_match), .owner(h_owner)
  );

  connect4_window_match u_match_v (
    .cell0(v_c[0]), .cell1(v_c[1]), .cell2(v_c[2]), .cell3(v_c[3]),
    .match(v_match), .owner(v_owner)
  );

  connect4_window_match u_match_dr (
    .cell0(dr_c[0]), .cell1(dr_c[1]), .cell2(dr_c[2]), .cell3(dr_c[3]),
    .match(dr_match), .owner(dr_owner)
  );

  connect4_window_match u_match_dl (
    .cell0(dl_c[0]), .cell1(dl_c[1]), .cell2(dl_c[2]), .cell3(dl_c[3]),
    .match(dl_match), .owner(dl_owner)
  );

  assign h_en  = (col <= MAX_H_COL);
  assign v_en  = (row <= MAX_V_ROW);
  assign dr_en = (row <= MAX_V_ROW) && (col <= MAX_H_COL);
  assign dl_en = (row <= MAX_V_ROW) && (col >= MIN_DL_COL);

  // Only the highest-priority window at this anchor contributes its mask.
  always_comb begin
    hit       = 1'b0;
    hit_owner = EMPTY;
    hit_mask  = '0;
    if (h_en && h_match) begin
      hit       = 1'b1;
      hit_owner = h_owner;
      hit_mask  = run_mask(anchor_base, 1);
    end else if (v_en && v_match) begin
      hit       = 1'b1;
      hit_owner = v_owner;
      hit_mask  = run_mask(anchor_base, COLS);
    end else if (dr_en && dr_match) begin
      hit       = 1'b1;
      hit_owner = dr_owner;
      hit_mask  = run_mask(anchor_base, COLS + 1);
    end else if (dl_en && dl_match) begin
      hit       = 1'b1;
      hit_owner = dl_owner;
      hit_mask  = run_mask(anchor_base, COLS - 1);
    end
  end

  assign scan_last = (idx == LAST_IDX);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (hit || scan_last) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state and results; clear behaves exactly like reset.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state    <= IDLE;
      winner   <= EMPTY;
      draw     <= 1'b0;
      win_mask <= '0;
    end else begin
      state <= state_next;
      if (state == SCAN && (hit || scan_last)) begin
        winner   <= hit_owner;
        // The final anchor's own emptiness must count toward the draw decision.
        draw     <= ~hit & ~(empty_seen | anchor_empty);
        win_mask <= hit_mask;
      end
    end
  end

  // Snapshot and scan position; fully reloaded on every accepted start.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      snap       <= tokens;
      idx        <= '0;
      row        <= '0;
      col        <= '0;
      empty_seen <= 1'b0;
    end else if (state == SCAN) begin
      empty_seen <= empty_seen | anchor_empty;
      idx        <= idx + 6'd1;
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

  assign busy = (state == SCAN);
  assign done = (state == REPORT);

endmodule

// File: tb/tb_connect4_win_checker.sv
// Directed bench for connect4_win_checker with a cycle-level reference model.
module tb_connect4_win_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        clear;
  logic [1:0]  tokens [6][7];
  logic        busy;
  logic        done;
  logic [1:0]  winner;
  logic        draw;
  logic [41:0] win_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  connect4_win_checker dut (
    .clock   (clock),
    .reset   (reset),
    .tokens  (tokens),
    .start   (start),
    .clear   (clear),
    .busy    (busy),
    .done    (done),
    .winner  (winner),
    .draw    (draw),
    .win_mask(win_mask)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Brute-force game rule: first anchor (row-major) with any run of four,
  // directions tried H, V, DR, DL; otherwise draw if no cell is empty/invalid.
  function automatic void model(input logic [1:0] b [6][7], output int k,
                                output logic [1:0] w, output logic [41:0] m,
                                output logic d);
    int dr [4];
    int dc [4];
    int r, c, rr, cc;
    logic ok, found;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    k = 41; w = 2'b00; m = '0; d = 1'b1; found = 1'b0;
    for (int i = 0; i < 42; i++)
      if (b[i / 7][i % 7] == 2'b00 || b[i / 7][i % 7] == 2'b11) d = 1'b0;
    for (int idx = 0; idx < 42; idx++) begin
      for (int dir = 0; dir < 4; dir++) begin
        if (!found) begin
          r = idx / 7; c = idx % 7;
          ok = (b[r][c] == 2'b01) || (b[r][c] == 2'b10);
          for (int s = 0; s < 4; s++) begin
            rr = r + dr[dir] * s; cc = c + dc[dir] * s;
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
            else if (b[rr][cc] != b[r][c]) ok = 1'b0;
          end
          if (ok) begin
            found = 1'b1; k = idx; w = b[r][c]; d = 1'b0;
            for (int s = 0; s < 4; s++) m[(r + dr[dir] * s) * 7 + c + dc[dir] * s] = 1'b1;
          end
        end
      end
    end
  endfunction

  // Reference timing: expected outputs after each rising edge.
  logic        armed = 1'b0;
  logic        m_active = 1'b0, m_done = 1'b0, m_d = 1'b0, p_d;
  logic [1:0]  m_w = 2'b00, p_w;
  logic [41:0] m_m = '0, p_m;
  int          m_left = 0, p_k;

  always @(posedge clock) begin
    if (reset) armed = 1'b1;
    if (reset || clear) begin
      m_active = 1'b0; m_done = 1'b0; m_w = 2'b00; m_d = 1'b0; m_m = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      m_left--;
      if (m_left == 0) begin
        m_active = 1'b0; m_done = 1'b1; m_w = p_w; m_d = p_d; m_m = p_m;
      end
    end else if (start) begin
      model(tokens, p_k, p_w, p_m, p_d);
      m_active = 1'b1;
      m_left   = p_k + 1;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      chk("winner", 64'(winner), 64'(m_w));
      chk("draw", 64'(draw), 64'(m_d));
      chk("win_mask", 64'(win_mask), 64'(m_m));
    end
  end

  task automatic empty_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) tokens[r][c] = 2'b00;
  endtask

  // Pulses start at the current negedge and returns the cycle count until done.
  task automatic run(input string name, output int lat);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 100) chk({name, "_timeout"}, 64'(lat), 64'd0);
    @(negedge clock);
  endtask

  int lat;
  int ndone;
  int done_at;

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    empty_board();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_winner", 64'(winner), 64'd0);
    chk("rst_draw", 64'(draw), 64'd0);
    chk("rst_mask", 64'(win_mask), 64'd0);

    // Horizontal run on the bottom row.
    empty_board();
    for (int c = 0; c < 4; c++) tokens[5][c] = 2'b01;
    run("t1", lat);
    chk("t1_latency", 64'(lat), 64'd37);
    chk("t1_winner", 64'(winner), 64'd1);
    chk("t1_draw", 64'(draw), 64'd0);
    chk("t1_mask", 64'(win_mask), 64'(42'hF << 35));

    // Vertical run in the rightmost column.
    empty_board();
    for (int r = 2; r < 6; r++) tokens[r][6] = 2'b10;
    run("t2", lat);
    chk("t2_latency", 64'(lat), 64'd22);
    chk("t2_winner", 64'(winner), 64'd2);
    chk("t2_mask", 64'(win_mask),
        64'((42'd1 << 20) | (42'd1 << 27) | (42'd1 << 34) | (42'd1 << 41)));

    // Full board without any run: rows A,A,B,B,A,A, A alternating 1/2.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        tokens[r][c] = (((c % 2) == 0) ^ (r == 2 || r == 3)) ? 2'b01 : 2'b10;
    run("t3", lat);
    chk("t3_latency", 64'(lat), 64'd43);
    chk("t3_winner", 64'(winner), 64'd0);
    chk("t3_draw", 64'(draw), 64'd1);
    chk("t3_mask", 64'(win_mask), 64'd0);
    tokens[0][0] = 2'b00;
    run("t3b", lat);
    chk("t3b_latency", 64'(lat), 64'd43);
    chk("t3b_draw", 64'(draw), 64'd0);

    // Two diagonals; the down-left one anchors earlier.
    empty_board();
    tokens[2][0] = 2'b01; tokens[3][1] = 2'b01; tokens[4][2] = 2'b01; tokens[5][3] = 2'b01;
    tokens[0][6] = 2'b10; tokens[1][5] = 2'b10; tokens[2][4] = 2'b10; tokens[3][3] = 2'b10;
    run("t4", lat);
    chk("t4_latency", 64'(lat), 64'd8);
    chk("t4_winner", 64'(winner), 64'd2);
    chk("t4_mask", 64'(win_mask),
        64'((42'd1 << 6) | (42'd1 << 12) | (42'd1 << 18) | (42'd1 << 24)));

    // Board and start changes mid-scan are ignored.
    empty_board();
    tokens[2][1] = 2'b01; tokens[3][1] = 2'b01; tokens[4][1] = 2'b01; tokens[5][1] = 2'b01;
    start = 1'b1;
    ndone = 0; done_at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (done === 1'b1) begin ndone++; done_at = n; end
      if (n == 5) begin empty_board(); start = 1'b1; end
      else start = 1'b0;
    end
    chk("t5_done_count", 64'(ndone), 64'd1);
    chk("t5_done_cycle", 64'(done_at), 64'd17);
    chk("t5_winner", 64'(winner), 64'd1);

    // Reset in the middle of a scan.
    for (int c = 0; c < 4; c++) tokens[5][c] = 2'b10;
    start = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
      start = 1'b0;
      reset = (n == 3);
    end
    chk("rmid_done_count", 64'(ndone), 64'd0);
    chk("rmid_winner", 64'(winner), 64'd0);

    // Clear during a winning scan, after a held result.
    empty_board();
    for (int c = 0; c < 4; c++) tokens[5][c] = 2'b01;
    run("t6a", lat);
    chk("t6a_winner", 64'(winner), 64'd1);
    start = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
      start = 1'b0;
      clear = (n == 10);
    end
    chk("t6_done_count", 64'(ndone), 64'd0);
    chk("t6_winner", 64'(winner), 64'd0);
    chk("t6_mask", 64'(win_mask), 64'd0);

    // Start and clear together: no scan.
    start = 1'b1; clear = 1'b1;
    @(negedge clock);
    start = 1'b0; clear = 1'b0;
    chk("t6b_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    chk("t6b_busy_later", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
